// File: rtl/cpu_pkg.sv
// Shared RV32M definitions: operand width, M-extension funct3 codes and the
// multiply/divide FSM state encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StDone
    } md_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitude and final
// sign correction.
module muldiv_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             en_i,
    input  logic [Width-1:0] val_i,
    output logic [Width-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (en_i) begin
            val_o = ~val_i + Width'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, shift-add
// multiply and restoring divide on a shared 2*XLEN accumulator.
module muldiv_unit #(
    parameter int unsigned XLEN = cpu_pkg::XLEN,
    parameter int unsigned ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            reg_write,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    import cpu_pkg::*;

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [4:0]        rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              sgna_q, sgna_d;

    logic              is_div, is_rem;
    logic              sign_a, sign_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_raw, div_fixed;
    logic [XLEN-1:0]   fix_val;

    assign is_div = op_q[2];
    assign is_rem = op_q[2] & op_q[1];
    assign sign_a = a_q[XLEN-1] &
                    (op_q inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM});
    assign sign_b = b_q[XLEN-1] & (op_q inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM});

    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (b_q == '1);

    muldiv_negate #(.Width(XLEN)) u_abs_a (
        .en_i  (sign_a),
        .val_i (a_q),
        .val_o (abs_a)
    );

    muldiv_negate #(.Width(XLEN)) u_abs_b (
        .en_i  (sign_b),
        .val_i (b_q),
        .val_o (abs_b)
    );

    // Accumulator layout: multiply keeps {partial product, multiplier}; divide keeps
    // {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};

    muldiv_negate #(.Width(2*XLEN)) u_fix_prod (
        .en_i  (neg_q),
        .val_i (acc_q),
        .val_o (prod_fixed)
    );

    assign div_raw = is_rem ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

    muldiv_negate #(.Width(XLEN)) u_fix_div (
        .en_i  (is_rem ? sgna_q : neg_q),
        .val_i (div_raw),
        .val_o (div_fixed)
    );

    always_comb begin
        fix_val = div_fixed;
        case (op_q)
            FUNCT3_MUL:                               fix_val = prod_fixed[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fix_val = prod_fixed[2*XLEN-1:XLEN];
            default:                                  fix_val = div_fixed;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        acc_d    = acc_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        sgna_d   = sgna_q;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (start) begin
                        op_d    = funct3;
                        a_d     = rs1_val;
                        b_d     = rs2_val;
                        rd_d    = rd_in;
                        state_d = StPrep;
                    end
                end
                StPrep: begin
                    neg_d  = sign_a ^ sign_b;
                    sgna_d = sign_a;
                    if (div_zero) begin
                        result_d = is_rem ? a_q : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = is_rem ? '0 : a_q;
                        state_d  = StDone;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        b_d     = abs_b;
                        cnt_d   = '0;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    if (is_div) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                        end
                    end else if (acc_q[0]) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(ITER - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_val;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            acc_q    <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sgna_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            sgna_q   <= sgna_d;
        end
    end

    assign busy      = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
    assign done      = (state_q == StDone);
    assign reg_write = done;
    assign rd_out    = rd_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, flush, reset,
// busy-time start and back-to-back issue.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, reg_write;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int n_chk = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .rd_out    (rd_out),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues in the current cycle and waits for done; poke>0 raises start with
    // junk operands in that cycle after issue, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, input int poke);
        int   lat;
        logic busy_ok;
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        step();
        start   = 1'b0;
        funct3  = 3'b101;
        rs1_val = $urandom;
        rs2_val = 32'h0;
        rd_in   = ~rd;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (lat == poke);
            step();
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
        chk({tag, "_wr"}, {31'b0, reg_write}, 32'd1);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_wr", {31'b0, reg_write}, 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_rd", {27'b0, rd_out}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();

        run_op("mul", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 35, 0);
        step();
        chk("mul_done_drop", {31'b0, done}, 32'd0);

        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 35, 0);
        step();
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 35, 12);
        step();
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 35, 0);
        step();

        run_op("divu0", 3'b101, 32'd100, 32'd0, 5'd4, 32'hFFFF_FFFF, 2, 0);
        step();
        run_op("remu0", 3'b111, 32'd100, 32'd0, 5'd6, 32'd100, 2, 0);
        step();
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 2, 0);
        step();
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 2, 0);
        step();

        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 35, 0);
        step();
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 35, 0);
        step();
        run_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'd1, 35, 0);
        step();

        // Flush mid-CALC: start in N, flush in N+10
        start   = 1'b1;
        funct3  = 3'b000;
        rs1_val = 32'd9;
        rs2_val = 32'd9;
        rd_in   = 5'd12;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("pre_flush_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_res", result, 32'd1);
        step();
        run_op("post_flush", 3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 35, 0);

        // Back-to-back from the DONE cycle, first write targets x0
        step();
        run_op("mul_x0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 35, 0);
        run_op("b2b", 3'b101, 32'd1000, 32'd10, 5'd14, 32'd100, 35, 0);
        step();

        // Asynchronous reset in the middle of CALC
        start   = 1'b1;
        funct3  = 3'b000;
        rs1_val = 32'd7;
        rs2_val = 32'd6;
        rd_in   = 5'd15;
        step();
        start = 1'b0;
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_wr", {31'b0, reg_write}, 32'd0);
        chk("arst_res", result, 32'd0);
        chk("arst_rd", {27'b0, rd_out}, 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("arst_idle", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
